// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the pipeline register chain.
//   pipe_state_t : hazard-unit command applied to every stage of the chain
//   PERF_CNT_W   : default width of the optional performance counters
//   pipe_stage_t : one stage entry at the default 64-bit payload width; the
//                  chain declares its own WIDTH-generic copy of this layout
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2,
    PIPE_FLUSH  = 2'd3
  } pipe_state_t;

  localparam int PERF_CNT_W  = 32;
  localparam int PIPE_DATA_W = 64;

  typedef struct packed {
    logic                   valid;
    logic                   halt;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_stage_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if -- bundle between a datapath stage and the register chain.
//   master : drives pipe_state, in_valid, in_data, in_halt;
//            observes out_valid, out_data, out_halt, occupancy
//   slave  : the chain itself (the opposite directions)
// With PIPE_PERF_EN defined the bundle also carries perf_stall_cnt,
// perf_bubble_cnt and perf_retire_cnt (PERF_CNT_W bits, driven by the slave).
interface pipe_stage_chain_if
  import cpu_types_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 1,
  parameter int PERF_CNT_W = cpu_types_pkg::PERF_CNT_W
) ();

  localparam int OCC_W = $clog2(DEPTH + 1);

  pipe_state_t        pipe_state;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_halt;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_halt;
  logic [OCC_W-1:0]   occupancy;

  if (PERF_CNT_W < 1) begin : g_perf_w_chk
    $error("pipe_stage_chain_if: PERF_CNT_W must be >= 1");
  end

`ifdef PIPE_PERF_EN
  logic [PERF_CNT_W-1:0] perf_stall_cnt;
  logic [PERF_CNT_W-1:0] perf_bubble_cnt;
  logic [PERF_CNT_W-1:0] perf_retire_cnt;

  modport master (
    output pipe_state, in_valid, in_data, in_halt,
    input  out_valid, out_data, out_halt, occupancy,
    input  perf_stall_cnt, perf_bubble_cnt, perf_retire_cnt
  );

  modport slave (
    input  pipe_state, in_valid, in_data, in_halt,
    output out_valid, out_data, out_halt, occupancy,
    output perf_stall_cnt, perf_bubble_cnt, perf_retire_cnt
  );
`else
  modport master (
    output pipe_state, in_valid, in_data, in_halt,
    input  out_valid, out_data, out_halt, occupancy
  );

  modport slave (
    input  pipe_state, in_valid, in_data, in_halt,
    output out_valid, out_data, out_halt, occupancy
  );
`endif

endinterface

// File: rtl/pipe_stage_chain_perf_counter.sv
// pipe_perf_counter -- saturating event counter.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset, clears the count
//   inc  : count one event on this edge
//   cnt  : current count, sticks at all-ones instead of wrapping
module pipe_perf_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain -- DEPTH-deep chain of pipeline registers, each holding a
// valid bit, a halt bit and a WIDTH-bit payload, all driven by one shared
// hazard-unit command.
//   CLK        : clock, rising edge
//   nRST       : asynchronous active-low reset
//   bus.slave  : pipe_state, in_valid/in_data/in_halt (head entry),
//                out_valid/out_data (last stage), out_halt (sticky halt),
//                occupancy (number of valid stages, registered)
// Optional: define PIPE_PERF_EN to build saturating stall / bubble / retire
// counters (PERF_CNT_W bits) that appear on the bus as perf_*_cnt.
// Every output comes straight from flops; nothing on the input side reaches an
// output combinationally.
module pipe_stage_chain
  import cpu_types_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 1,
  parameter int PERF_CNT_W = cpu_types_pkg::PERF_CNT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  pipe_stage_chain_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_depth_chk
    $error("pipe_stage_chain: DEPTH must be >= 1");
  end

  if (PERF_CNT_W < 1) begin : g_perf_w_chk
    $error("pipe_stage_chain: PERF_CNT_W must be >= 1");
  end

  typedef struct packed {
    logic             valid;
    logic             halt;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_q [DEPTH];
  stage_t           stage_d [DEPTH];
  stage_t           head;
  logic             sticky_q;
  logic             sticky_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             last_halt;

  // A halt only counts on a valid entry; with the invalid-stage-is-zero
  // invariant the AND is redundant, but it keeps the intent explicit.
  assign last_halt = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].halt;

  always_comb begin
    // Squash payload and halt of an invalid head so bubbles stay all-zero.
    head = '0;
    if (bus.in_valid) begin
      head.valid = 1'b1;
      head.halt  = bus.in_halt;
      head.data  = bus.in_data;
    end

    stage_d = stage_q;
    case (bus.pipe_state)
      PIPE_ENABLE, PIPE_NOP: begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          stage_d[i] = stage_q[i-1];
        end
        stage_d[0] = (bus.pipe_state == PIPE_ENABLE) ? head : '0;
      end
      PIPE_FLUSH: begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_d[i] = '0;
        end
      end
      default: begin
        // PIPE_STALL: every stage holds
      end
    endcase

    sticky_d = sticky_q | last_halt;

    // Occupancy is tracked from the next-state valids so it stays a flop.
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(stage_d[i].valid);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      sticky_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      stage_q  <= stage_d;
      sticky_q <= sticky_d;
      occ_q    <= occ_d;
    end
  end

  assign bus.out_valid = stage_q[DEPTH-1].valid;
  assign bus.out_data  = stage_q[DEPTH-1].data;
  assign bus.out_halt  = sticky_q | last_halt;
  assign bus.occupancy = occ_q;

`ifdef PIPE_PERF_EN
  logic stall_inc;
  logic bubble_inc;
  logic retire_inc;

  always_comb begin
    stall_inc  = (bus.pipe_state == PIPE_STALL);
    // Stage 0 loads a bubble on NOP, FLUSH, or ENABLE without a valid head;
    // a STALL holds stage 0 rather than loading it.
    bubble_inc = (bus.pipe_state == PIPE_NOP) || (bus.pipe_state == PIPE_FLUSH) ||
                 ((bus.pipe_state == PIPE_ENABLE) && !bus.in_valid);
    // An entry retires when it leaves the last stage by shifting out.
    retire_inc = stage_q[DEPTH-1].valid &&
                 ((bus.pipe_state == PIPE_ENABLE) || (bus.pipe_state == PIPE_NOP));
  end

  pipe_perf_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (bus.perf_stall_cnt)
  );

  pipe_perf_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (bubble_inc),
    .cnt  (bus.perf_bubble_cnt)
  );

  pipe_perf_counter #(.W(PERF_CNT_W)) u_retire_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (retire_inc),
    .cnt  (bus.perf_retire_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: four chains (DEPTH 3, 2, 4, 1; the DEPTH=1 one
// has 4-bit perf counters) share one stimulus stream. Directed scenarios look
// at one chain each; the random scenario checks all four against a reference
// model of the chain as an array of entries.
module tb_pipe_stage_chain;
  import cpu_types_pkg::*;

  localparam int NDUT = 4;

  function automatic int dep_of(int k);
    case (k)
      0: return 3;
      1: return 2;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int pw_of(int k);
    return (k == 3) ? 4 : 32;
  endfunction

  logic        CLK  = 1'b0;
  logic        nRST = 1'b0;
  pipe_state_t cmd  = PIPE_ENABLE;
  logic        vin  = 1'b0;
  logic        hin  = 1'b0;
  logic [63:0] din  = '0;

  always #5 CLK = ~CLK;

  logic        ov [NDUT];
  logic [63:0] od [NDUT];
  logic        oh [NDUT];
  logic [31:0] oc [NDUT];
`ifdef PIPE_PERF_EN
  logic [31:0] pst [NDUT];
  logic [31:0] pbu [NDUT];
  logic [31:0] pre [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int D  = dep_of(g);
    localparam int PW = pw_of(g);

    pipe_stage_chain_if #(.WIDTH(64), .DEPTH(D), .PERF_CNT_W(PW)) bus ();

    assign bus.pipe_state = cmd;
    assign bus.in_valid   = vin;
    assign bus.in_data    = din;
    assign bus.in_halt    = hin;

    pipe_stage_chain #(.WIDTH(64), .DEPTH(D), .PERF_CNT_W(PW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
    );

    assign ov[g] = bus.out_valid;
    assign od[g] = bus.out_data;
    assign oh[g] = bus.out_halt;
    assign oc[g] = 32'(bus.occupancy);
`ifdef PIPE_PERF_EN
    assign pst[g] = 32'(bus.perf_stall_cnt);
    assign pbu[g] = 32'(bus.perf_bubble_cnt);
    assign pre[g] = 32'(bus.perf_retire_cnt);
`endif
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: entry slots per chain, slot 0 = head, slot dep-1 = output.
  logic        mv [NDUT][4];
  logic        mh [NDUT][4];
  logic [63:0] md [NDUT][4];
  logic        msticky [NDUT];
  longint      mst [NDUT];
  longint      mbu [NDUT];
  longint      mre [NDUT];

  function automatic void mreset();
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0; mh[k][i] = 1'b0; md[k][i] = '0;
      end
      msticky[k] = 1'b0; mst[k] = 0; mbu[k] = 0; mre[k] = 0;
    end
  endfunction

  function automatic void madvance(pipe_state_t c, logic v, logic [63:0] d, logic h);
    for (int k = 0; k < NDUT; k++) begin
      int     last = dep_of(k) - 1;
      longint mx   = (longint'(1) << pw_of(k)) - 1;
      bit     load = (c == PIPE_ENABLE) && v;
      if (c == PIPE_STALL && mst[k] < mx) mst[k]++;
      if (c != PIPE_STALL && !load && mbu[k] < mx) mbu[k]++;
      if ((c == PIPE_ENABLE || c == PIPE_NOP) && mv[k][last] && mre[k] < mx) mre[k]++;
      if (mv[k][last] && mh[k][last]) msticky[k] = 1'b1;
      if (c == PIPE_ENABLE || c == PIPE_NOP) begin
        for (int i = last; i > 0; i--) begin
          mv[k][i] = mv[k][i-1]; mh[k][i] = mh[k][i-1]; md[k][i] = md[k][i-1];
        end
        mv[k][0] = load;
        mh[k][0] = load && h;
        md[k][0] = load ? d : 64'd0;
      end else if (c == PIPE_FLUSH) begin
        for (int i = 0; i <= last; i++) begin
          mv[k][i] = 1'b0; mh[k][i] = 1'b0; md[k][i] = '0;
        end
      end
    end
  endfunction

  function automatic int mocc(int k);
    int n = 0;
    for (int i = 0; i < dep_of(k); i++) n += int'(mv[k][i]);
    return n;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    cmd = PIPE_ENABLE; vin = 1'b0; din = '0; hin = 1'b0;
    mreset();
    #2;
    nRST = 1'b1;
    #1;
  endtask

  // Drive one command between edges, advance the model, sample 1 after the edge.
  task automatic cycle(pipe_state_t c, logic v, logic [63:0] d, logic h);
    @(negedge CLK);
    cmd = c; vin = v; din = d; hin = h;
    madvance(c, v, d, h);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NDUT; k++) begin
      n_total++; if (ov[k] !== 1'b0) $display("FAIL reset_valid dut%0d got %0b exp 0", k, ov[k]); else n_pass++;
      n_total++; if (od[k] !== 64'd0) $display("FAIL reset_data dut%0d got %h exp 0", k, od[k]); else n_pass++;
      n_total++; if (oh[k] !== 1'b0) $display("FAIL reset_halt dut%0d got %0b exp 0", k, oh[k]); else n_pass++;
      n_total++; if (oc[k] !== 32'd0) $display("FAIL reset_occ dut%0d got %0d exp 0", k, oc[k]); else n_pass++;
`ifdef PIPE_PERF_EN
      n_total++; if (pst[k] !== 32'd0) $display("FAIL reset_perf dut%0d got %0d exp 0", k, pst[k]); else n_pass++;
`endif
    end
  endtask

  task automatic test_latency();
    do_reset();
    cycle(PIPE_ENABLE, 1'b1, 64'hA, 1'b0);
    cycle(PIPE_ENABLE, 1'b1, 64'hB, 1'b0);
    n_total++; if (ov[0] !== 1'b0) $display("FAIL lat_early dut0 got %0b exp 0", ov[0]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b1, 64'hC, 1'b0);
    n_total++; if (ov[0] !== 1'b1 || od[0] !== 64'hA) $display("FAIL lat_a dut0 got %0b/%h exp 1/a", ov[0], od[0]); else n_pass++;
    n_total++; if (oc[0] !== 32'd3) $display("FAIL lat_occ dut0 got %0d exp 3", oc[0]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
    n_total++; if (od[0] !== 64'hB) $display("FAIL lat_b dut0 got %h exp b", od[0]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
    n_total++; if (od[0] !== 64'hC || oc[0] !== 32'd1) $display("FAIL lat_c dut0 got %h/%0d exp c/1", od[0], oc[0]); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    cycle(PIPE_ENABLE, 1'b1, 64'h11, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(PIPE_STALL, 1'b1, 64'h99, 1'b0);
      n_total++; if (oc[0] !== 32'd1) $display("FAIL stall_occ dut0 cyc%0d got %0d exp 1", i, oc[0]); else n_pass++;
    end
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
    n_total++; if (ov[0] !== 1'b0) $display("FAIL stall_early dut0 got %0b exp 0", ov[0]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
    n_total++; if (ov[0] !== 1'b1 || od[0] !== 64'h11) $display("FAIL stall_out dut0 got %0b/%h exp 1/11", ov[0], od[0]); else n_pass++;
    n_total++; if (oc[0] !== 32'd1) $display("FAIL stall_drop dut0 got %0d exp 1", oc[0]); else n_pass++;
`ifdef PIPE_PERF_EN
    n_total++; if (pst[0] !== 32'd2) $display("FAIL stall_cnt dut0 got %0d exp 2", pst[0]); else n_pass++;
`endif
  endtask

  task automatic test_nop_bubble();
    do_reset();
    cycle(PIPE_ENABLE, 1'b1, 64'h5, 1'b0);
    cycle(PIPE_NOP, 1'b1, 64'hEE, 1'b0);
    n_total++; if (ov[1] !== 1'b1 || od[1] !== 64'h5) $display("FAIL nop_first dut1 got %0b/%h exp 1/5", ov[1], od[1]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b1, 64'h6, 1'b0);
    n_total++; if (ov[1] !== 1'b0 || od[1] !== 64'h0) $display("FAIL nop_bubble dut1 got %0b/%h exp 0/0", ov[1], od[1]); else n_pass++;
`ifdef PIPE_PERF_EN
    n_total++; if (pbu[1] !== 32'd1) $display("FAIL nop_bubble_cnt dut1 got %0d exp 1", pbu[1]); else n_pass++;
`endif
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
    n_total++; if (ov[1] !== 1'b1 || od[1] !== 64'h6) $display("FAIL nop_second dut1 got %0b/%h exp 1/6", ov[1], od[1]); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(PIPE_ENABLE, 1'b1, 64'h100 + 64'(i), 1'b0);
    n_total++; if (oc[2] !== 32'd4 || od[2] !== 64'h100) $display("FAIL flush_fill dut2 got %0d/%h exp 4/100", oc[2], od[2]); else n_pass++;
    cycle(PIPE_FLUSH, 1'b1, 64'hFF, 1'b0);
    n_total++; if (oc[2] !== 32'd0 || ov[2] !== 1'b0 || od[2] !== 64'd0) $display("FAIL flush_clear dut2 got %0d/%0b/%h exp 0/0/0", oc[2], ov[2], od[2]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
      n_total++; if (ov[2] !== 1'b0 || od[2] !== 64'd0) $display("FAIL flush_drain dut2 cyc%0d got %0b/%h exp 0/0", i, ov[2], od[2]); else n_pass++;
    end
  endtask

  task automatic test_halt_sticky();
    do_reset();
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b1);
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b1);
    n_total++; if (oh[1] !== 1'b0) $display("FAIL halt_ignored dut1 got %0b exp 0", oh[1]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b1, 64'h77, 1'b1);
    n_total++; if (oh[1] !== 1'b0) $display("FAIL halt_early dut1 got %0b exp 0", oh[1]); else n_pass++;
    cycle(PIPE_ENABLE, 1'b0, 64'h0, 1'b0);
    n_total++; if (oh[1] !== 1'b1 || ov[1] !== 1'b1) $display("FAIL halt_arrive dut1 got %0b/%0b exp 1/1", oh[1], ov[1]); else n_pass++;
    cycle(PIPE_FLUSH, 1'b0, 64'h0, 1'b0);
    n_total++; if (oh[1] !== 1'b1 || ov[1] !== 1'b0) $display("FAIL halt_flush dut1 got %0b/%0b exp 1/0", oh[1], ov[1]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(PIPE_ENABLE, 1'b1, 64'h50 + 64'(i), 1'b0);
      n_total++; if (oh[1] !== 1'b1) $display("FAIL halt_hold dut1 cyc%0d got %0b exp 1", i, oh[1]); else n_pass++;
    end
    do_reset();
    n_total++; if (oh[1] !== 1'b0) $display("FAIL halt_reset dut1 got %0b exp 0", oh[1]); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(PIPE_ENABLE, 1'b1, 64'hC0 + 64'(i), 1'b1);
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    mreset();
    #1;
    n_total++; if (ov[0] !== 1'b0 || od[0] !== 64'd0 || oc[0] !== 32'd0) $display("FAIL async_clear dut0 got %0b/%h/%0d exp 0/0/0", ov[0], od[0], oc[0]); else n_pass++;
    n_total++; if (oh[0] !== 1'b0) $display("FAIL async_halt dut0 got %0b exp 0", oh[0]); else n_pass++;
    nRST = 1'b1;
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(PIPE_STALL, 1'b0, 64'h0, 1'b0);
      if (i == 13) begin
        n_total++; if (pst[3] !== 32'd14) $display("FAIL sat_before dut3 got %0d exp 14", pst[3]); else n_pass++;
      end
    end
    n_total++; if (pst[3] !== 32'd15) $display("FAIL sat_hold dut3 got %0d exp 15", pst[3]); else n_pass++;
    n_total++; if (pst[0] !== 32'd20) $display("FAIL sat_wide dut0 got %0d exp 20", pst[0]); else n_pass++;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pipe_state_t c;
      int r = int'($urandom_range(0, 9));
      if (n == 200) do_reset();
      if (r <= 5) c = PIPE_ENABLE;
      else if (r <= 7) c = PIPE_STALL;
      else if (r == 8) c = PIPE_NOP;
      else c = PIPE_FLUSH;
      cycle(c, $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 15) == 0);
      for (int k = 0; k < NDUT; k++) begin
        int last = dep_of(k) - 1;
        logic eh = msticky[k] | (mv[k][last] & mh[k][last]);
        n_total++; if (ov[k] !== mv[k][last]) $display("FAIL rnd_valid dut%0d n%0d got %0b exp %0b", k, n, ov[k], mv[k][last]); else n_pass++;
        n_total++; if (od[k] !== md[k][last]) $display("FAIL rnd_data dut%0d n%0d got %h exp %h", k, n, od[k], md[k][last]); else n_pass++;
        n_total++; if (oh[k] !== eh) $display("FAIL rnd_halt dut%0d n%0d got %0b exp %0b", k, n, oh[k], eh); else n_pass++;
        n_total++; if (oc[k] !== 32'(mocc(k))) $display("FAIL rnd_occ dut%0d n%0d got %0d exp %0d", k, n, oc[k], mocc(k)); else n_pass++;
`ifdef PIPE_PERF_EN
        n_total++; if (pst[k] !== 32'(mst[k])) $display("FAIL rnd_stall_cnt dut%0d n%0d got %0d exp %0d", k, n, pst[k], mst[k]); else n_pass++;
        n_total++; if (pbu[k] !== 32'(mbu[k])) $display("FAIL rnd_bubble_cnt dut%0d n%0d got %0d exp %0d", k, n, pbu[k], mbu[k]); else n_pass++;
        n_total++; if (pre[k] !== 32'(mre[k])) $display("FAIL rnd_retire_cnt dut%0d n%0d got %0d exp %0d", k, n, pre[k], mre[k]); else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    mreset();
    test_reset();
    test_latency();
    test_stall();
    test_nop_bubble();
    test_flush();
    test_halt_sticky();
    test_async_reset();
`ifdef PIPE_PERF_EN
    test_perf_saturate();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
